// File: rtl/cordic_disp_pkg.sv
// Shared types and constants for the CORDIC result display path.
package cordic_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SEND
    } state_t;

    localparam logic [7:0] ASCII_ZERO     = 8'h30;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    // Double-dabble correction: a nibble that would reach 10 or more after
    // the next shift is pre-biased by 3 so the carry lands in the next digit.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= BCD_ADJ_THRESH) ? nib + BCD_ADJ : nib;
    endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// Sequential binary-to-BCD converter: one add-3-then-shift step per cycle.
module bcd_shift_core
    import cordic_disp_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  step,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [BCD_W-1:0]  bcd;
    logic [DATA_W-1:0] bin;
    logic [CNT_W-1:0]  cnt;
    logic [BCD_W-1:0]  bcd_adj;

    // Per-nibble add-3 correction applied ahead of the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = bcd_adjust(bcd[4*i +: 4]);
        end
    end

    // Shift register and step counter; load restarts a conversion from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd <= '0;
            bin <= '0;
            cnt <= '0;
        end else if (load) begin
            bcd <= '0;
            bin <= data_in;
            cnt <= '0;
        end else if (step) begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
            cnt        <= cnt + 1'b1;
        end
    end

    // Flags the step that performs the final shift, so the caller can leave
    // CONVERT on the same edge that completes the conversion.
    assign done    = step && (cnt == CNT_W'(DATA_W - 1));
    assign bcd_out = bcd;

endmodule

// File: rtl/bcd_display_scheduler.sv
// Round-robin arbiter feeding one shared BCD converter, streaming ASCII digits.
module bcd_display_scheduler
    import cordic_disp_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 12,
    parameter int DIGITS = 4,
    parameter int TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_char,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_last
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W = 4 * DIGITS;

    state_t             state;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   winner;
    logic [TAG_W-1:0]   cand;
    logic               any_req;
    logic [IDX_W-1:0]   idx;
    logic [BCD_W-1:0]   bcd;
    logic [DATA_W-1:0]  win_data;
    logic [3:0]         cur_digit;
    logic               core_done;
    logic               load;
    logic               step;

    // Round-robin search: walk requesters starting at rr_ptr, first hit wins.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
            cand = (cand == TAG_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Select the winning requester's value for capture.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == TAG_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign load = (state == IDLE) && any_req;
    assign step = (state == CONVERT);

    // One-hot grant pulse in the capture cycle; held off while reset is high.
    always_comb begin
        gnt = '0;
        if (load && !reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                gnt[i] = (winner == TAG_W'(i));
            end
        end
    end

    bcd_shift_core #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data_in (win_data),
        .step    (step),
        .done    (core_done),
        .bcd_out (bcd)
    );

    // Controller: grant, convert for DATA_W cycles, then hand out digits MSD first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= CONVERT;
                        busy    <= 1'b1;
                        out_tag <= winner;
                        rr_ptr  <= (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    end
                end
                CONVERT: begin
                    if (core_done) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        idx       <= IDX_W'(DIGITS - 1);
                        out_last  <= (DIGITS == 1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= idx - 1'b1;
                            out_last <= (idx == IDX_W'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit mux: pick the nibble addressed by idx and convert to ASCII.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = bcd[4*i +: 4];
            end
        end
    end

    assign out_char = (state == SEND) ? ASCII_ZERO + {4'h0, cur_digit} : 8'h00;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed bench for bcd_display_scheduler with hand-computed digit strings.
module tb_bcd_display_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [35:0] req_data;
    logic [2:0]  gnt;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic [1:0]  out_tag;
    logic        out_last;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bcd_display_scheduler #(
        .N_REQ  (3),
        .DATA_W (12),
        .DIGITS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_tag   (out_tag),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Wait (bounded) for a grant pulse and compare it.
    task automatic grant_wait(input logic [2:0] exp_gnt, output int gcyc);
        int n;
        n = 0;
        #1;
        while (gnt == 3'b000 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("gnt", 32'(gnt), 32'(exp_gnt));
        gcyc = cyc;
    endtask

    // Called at the grant cycle; follows the value through to the next IDLE cycle.
    task automatic collect(input int val, input int tagx, input logic [2:0] drop,
                           input logic [2:0] raise, input int stall_digit);
        int dig[4];
        int v;
        int lat;
        v = val;
        for (int i = 0; i < 4; i++) begin
            dig[i] = v % 10;
            v      = v / 10;
        end
        @(negedge clk);
        req = req & ~drop;
        lat = 1;
        check("busy_t1", 32'(busy), 32'd1);
        check("gnt_pulse", 32'(gnt), 32'd0);
        check("valid_t1", 32'(out_valid), 32'd0);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5) req = req | raise;
        end
        check("latency", 32'(lat), 32'd13);
        for (int d = 3; d >= 0; d--) begin
            if (d == stall_digit) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_char", 32'(out_char), 32'(32'h30 + dig[d]));
                    check("stall_last", 32'(out_last), 32'd0);
                end
                out_ready = 1'b1;
            end
            check("valid", 32'(out_valid), 32'd1);
            check("char", 32'(out_char), 32'(32'h30 + dig[d]));
            check("tag", 32'(out_tag), 32'(tagx));
            check("last", 32'(out_last), 32'(d == 0));
            @(negedge clk);
        end
        check("busy_end", 32'(busy), 32'd0);
        check("valid_end", 32'(out_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_char"}, 32'(out_char), 32'd0);
        check({tag, "_tag"}, 32'(out_tag), 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, g2, g3, seen, n;
        reset     = 1'b1;
        req       = 3'b000;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // 4095 on requester 0
        req_data[0 +: 12] = 12'd4095;
        req = 3'b001;
        grant_wait(3'b001, g0);
        collect(4095, 0, 3'b001, 3'b000, -1);

        // 0 on requester 1, 7 on requester 2
        req_data[12 +: 12] = 12'd0;
        req = 3'b010;
        grant_wait(3'b010, g0);
        collect(0, 1, 3'b010, 3'b000, -1);
        req_data[24 +: 12] = 12'd7;
        req = 3'b100;
        grant_wait(3'b100, g0);
        collect(7, 2, 3'b100, 3'b000, -1);

        // All three held: round-robin 0,1,2,0 at 17-cycle spacing
        req_data = {12'd300, 12'd200, 12'd100};
        req = 3'b111;
        grant_wait(3'b001, g0);
        collect(100, 0, 3'b000, 3'b000, -1);
        grant_wait(3'b010, g1);
        check("spacing01", 32'(g1 - g0), 32'd17);
        collect(200, 1, 3'b000, 3'b000, -1);
        grant_wait(3'b100, g2);
        check("spacing12", 32'(g2 - g1), 32'd17);
        collect(300, 2, 3'b000, 3'b000, -1);
        grant_wait(3'b001, g3);
        check("spacing20", 32'(g3 - g2), 32'd17);
        collect(100, 0, 3'b111, 3'b000, -1);

        // 1000 on requester 1
        req_data[12 +: 12] = 12'd1000;
        req = 3'b010;
        grant_wait(3'b010, g0);
        collect(1000, 1, 3'b010, 3'b000, -1);

        // Backpressure on the second digit of 4095
        req_data[24 +: 12] = 12'd4095;
        req = 3'b100;
        grant_wait(3'b100, g0);
        collect(4095, 2, 3'b100, 3'b000, 2);

        // Request raised while busy is served in the first IDLE cycle
        req_data[0 +: 12]  = 12'd555;
        req_data[12 +: 12] = 12'd42;
        req = 3'b001;
        grant_wait(3'b001, g0);
        collect(555, 0, 3'b001, 3'b010, -1);
        check("gnt_after_busy", 32'(gnt), 32'b010);
        collect(42, 1, 3'b010, 3'b000, -1);

        // Reset during CONVERT (pointer is 1 after this grant)
        req_data[0 +: 12] = 12'd1234;
        req = 3'b001;
        grant_wait(3'b001, g0);
        @(negedge clk);
        req = 3'b000;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_conv");
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_chars_after_rst_conv", 32'(seen), 32'd0);

        // Pointer restarted at 0: requester 0 beats requester 1
        req_data[0 +: 12]  = 12'd321;
        req_data[12 +: 12] = 12'd654;
        req = 3'b011;
        grant_wait(3'b001, g0);
        collect(321, 0, 3'b011, 3'b000, -1);

        // Reset during SEND after one character
        req_data[12 +: 12] = 12'd4095;
        req = 3'b010;
        grant_wait(3'b010, g0);
        @(negedge clk);
        req = 3'b000;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("send_reached", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("send_second_char", 32'(out_char), 32'h30);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_send");
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_chars_after_rst_send", 32'(seen), 32'd0);

        // After release: requester 2 alone, then 0 wins over 1
        req_data[24 +: 12] = 12'd89;
        req = 3'b100;
        grant_wait(3'b100, g0);
        collect(89, 2, 3'b100, 3'b000, -1);
        req_data[0 +: 12]  = 12'd2024;
        req_data[12 +: 12] = 12'd11;
        req = 3'b011;
        grant_wait(3'b001, g0);
        collect(2024, 0, 3'b001, 3'b000, -1);
        check("gnt_second_of_pair", 32'(gnt), 32'b010);
        collect(11, 1, 3'b010, 3'b000, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scheduler.md
# bcd_display_scheduler

Sequential controller that shares one binary-to-BCD conversion engine among several result producers in the CORDIC processor (cosine, sine, angle). It arbitrates round-robin between requesters, captures one 12-bit unsigned value, and converts it with a clocked double-dabble sequence of one shift per cycle. It then streams the decimal digits as ASCII characters, with valid/ready backpressure, to the display/character sink.

## Interface
- N_REQ, 3, number of requesters (1..8)
- DATA_W, 12, width of each unsigned binary value
- DIGITS, 4, decimal digits emitted per value; the integrator guarantees 10^DIGITS > 2^DATA_W - 1
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  N_REQ  per-requester request level; held until granted
- req_data  in  N_REQ*DATA_W  requester i value in bits [i*DATA_W +: DATA_W]; stable while req[i] is high
- gnt  out  N_REQ  one-hot, 1-cycle pulse; the value of the granted requester is captured on this edge
- busy  out  1  high whenever state is not IDLE
- out_valid  out  1  character available
- out_ready  in  1  sink accepts the character when out_valid and out_ready are both high at a rising edge
- out_char  out  8  ASCII digit, 8'h30 + BCD digit, most significant digit first
- out_tag  out  clog2(N_REQ) (min 1)  index of the requester that owns the current character
- out_last  out  1  high with the final digit of a value

## Operation
- The FSM has three states: IDLE, CONVERT and SEND.
- **IDLE**
  - If any req bit is high, pick the winner by round-robin starting at rr_ptr.
  - Assert gnt for that winner combinationally in this cycle, and load its data into the shift register on this edge.
  - Clear the BCD field, set rr_ptr = winner+1 mod N_REQ, and move to CONVERT.
- **CONVERT**
  - Runs exactly DATA_W cycles.
  - Each cycle, every BCD nibble >= 5 gets +3, then the combined {bcd, bin} register shifts left by 1.
  - The add-3 step is applied before the shift in the same cycle.
  - The shift counter is log2-sized and resets to 0 on entry.
  - After the DATA_W-th shift, move to SEND with the digit index set to DIGITS-1.
- **SEND**
  - Drive out_valid=1, out_char = 8'h30 + nibble[digit index], and out_tag = the latched winner.
  - out_last = (index == 0).
  - On each handshake, decrement the index.
  - A handshake with out_last=1 returns the FSM to IDLE.
- Leading zeros are emitted; the output is always fixed width, DIGITS characters.
- Requests that arrive outside IDLE are not granted and not lost. They are seen at the next IDLE cycle as long as they are still held.
- Only the binary-to-BCD data path exists; there is no sign or overflow handling. With the defaults, values up to 4095 are exact.

## Timing
- Reset values: state=IDLE, rr_ptr=0, gnt=0, busy=0, out_valid=0, out_char=8'h00, out_tag=0, out_last=0, and all internal registers 0.
- Reset asserted mid-CONVERT or mid-SEND aborts the value immediately and asynchronously. No further characters are emitted, and the next grant after reset starts at requester 0.
- Grant in cycle T → busy=1 from T+1, CONVERT during T+1..T+DATA_W, first out_valid at T+DATA_W+1.
- With out_ready held high, the DIGITS characters go out in consecutive cycles and IDLE is re-entered at T+DATA_W+DIGITS+1.
- Minimum grant-to-grant spacing is 1+DATA_W+DIGITS = 17 cycles with the defaults.
- While out_valid=1 and out_ready=0, out_char, out_tag and out_last hold stable. out_valid never drops without a handshake (except on reset).
- out_ready is ignored outside SEND.
- Simultaneous requests are resolved by round-robin only; the pointer moves only on a grant.

## Structure
- A shared package `cordic_disp_pkg` holds:
  - the state enum {IDLE, CONVERT, SEND};
  - ASCII_ZERO = 8'h30;
  - the BCD_ADJ_THRESH = 4'd5 and BCD_ADJ = 4'd3 constants.
- One sub-module, `bcd_shift_core`, contains the {bcd, bin} register, the per-nibble add-3 logic and the shift counter. Its ports are load, data_in, step, done and bcd_out.
- The top level contains the arbiter, the FSM and the output digit mux.

## Test plan
- req[0]=1 with value 12'd4095, out_ready=1 → gnt[0] pulse at T; chars "4","0","9","5" (8'h34,30,39,35) at T+13..T+16; out_last only on "5"; out_tag=0.
- Value 0 → "0000"; value 12'd7 → "0007"; value 12'd1000 → "1000".
- req=3'b111 held, with values 100/200/300 → grants go to 0,1,2,0 in that order, 17 cycles apart; the tags match and the digits read "0100","0200","0300".
- Backpressure: out_ready=0 for 5 cycles on the 2nd digit of 4095 → "0" is held stable with out_valid=1; the stream resumes with no loss or duplication.
- Reset pulse during CONVERT and during SEND → all outputs return to 0 asynchronously. After release, req[2] alone is granted, and afterwards req[0] wins over req[1] (rr_ptr=0).
- req[1] raised while busy and held → granted in the first IDLE cycle after the prior out_last handshake.
